// File: rtl/dmem_timer_slave.sv
// Data-memory responder: word RAM (region 0x0) plus optional machine timer (region 0x2).
// The timer region, prescaler and interrupt are built only when DMEM_TIMER_EN is defined.
module dmem_timer_slave #(
  parameter int DEPTH    = 4096,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_re_i,
  input  logic [31:0] ram_raddr_i,
  output logic [31:0] ram_data_o,
  input  logic        ram_we_i,
  input  logic [31:0] ram_waddr_i,
  input  logic [31:0] ram_data_i,
  output logic        timer_irq_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;
  logic          ram_wsel;
  logic          unused_addr;

  assign ridx     = ram_raddr_i[AW+1:2];
  assign widx     = ram_waddr_i[AW+1:2];
  assign ram_wsel = ram_we_i && !rst && (ram_waddr_i[31:28] == 4'h0);

  // Upper in-region bits alias and byte offsets are ignored.
  assign unused_addr = ^{ram_raddr_i[27:AW+2], ram_raddr_i[1:0],
                         ram_waddr_i[27:AW+2], ram_waddr_i[1:0]};

  // Combinational read: the core's load stage expects data in the issuing cycle.
  always_ff @(posedge clk) begin
    if (ram_wsel) begin
      mem[widx] <= ram_data_i;
    end
  end

`ifdef DMEM_TIMER_EN
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PCW-1:0] pcnt_reg, pcnt_next;
  logic [63:0]    mtime_reg, mtime_next;
  logic [63:0]    mtimecmp_reg, mtimecmp_next;
  logic           en_reg, en_next;
  logic           irq_reg, irq_next;
  logic           tick;
  logic           tmr_wsel;
  logic [31:0]    tmr_rdata;

  assign tmr_wsel = ram_we_i && (ram_waddr_i[31:28] == 4'h2);
  assign tick     = en_reg && (pcnt_reg == PCW'(PRESCALE - 1));

  always_comb begin
    pcnt_next     = pcnt_reg;
    mtime_next    = mtime_reg;
    mtimecmp_next = mtimecmp_reg;
    en_next       = en_reg;
    irq_next      = en_reg && (mtime_reg >= mtimecmp_reg);

    if (!en_reg) begin
      pcnt_next = '0;
    end else if (tick) begin
      pcnt_next  = '0;
      mtime_next = mtime_reg + 64'd1;
    end else begin
      pcnt_next = pcnt_reg + PCW'(1);
    end

    // A software write to either mtime half discards that cycle's increment entirely.
    if (tmr_wsel) begin
      case (ram_waddr_i[4:2])
        3'd0:    mtime_next = {mtime_reg[63:32], ram_data_i};
        3'd1:    mtime_next = {ram_data_i, mtime_reg[31:0]};
        3'd2:    mtimecmp_next = {mtimecmp_reg[63:32], ram_data_i};
        3'd3:    mtimecmp_next = {ram_data_i, mtimecmp_reg[31:0]};
        3'd4:    en_next = ram_data_i[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_reg     <= '0;
      mtime_reg    <= '0;
      mtimecmp_reg <= '1;
      en_reg       <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      pcnt_reg     <= pcnt_next;
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      en_reg       <= en_next;
      irq_reg      <= irq_next;
    end
  end

  always_comb begin
    tmr_rdata = '0;
    case (ram_raddr_i[4:2])
      3'd0:    tmr_rdata = mtime_reg[31:0];
      3'd1:    tmr_rdata = mtime_reg[63:32];
      3'd2:    tmr_rdata = mtimecmp_reg[31:0];
      3'd3:    tmr_rdata = mtimecmp_reg[63:32];
      3'd4:    tmr_rdata = {31'd0, en_reg};
      default: tmr_rdata = '0;
    endcase
  end

  assign timer_irq_o = irq_reg;
`else
  assign timer_irq_o = 1'b0;
`endif

  always_comb begin
    ram_data_o = '0;
    if (ram_re_i) begin
      if (ram_raddr_i[31:28] == 4'h0) begin
        ram_data_o = mem[ridx];
      end
`ifdef DMEM_TIMER_EN
      else if (ram_raddr_i[31:28] == 4'h2) begin
        ram_data_o = tmr_rdata;
      end
`endif
    end
  end

endmodule
